seq_bit_serializer: RTL and testbench
=====================================

Name: seq_bit_serializer

Overview:
- Parallel-in, serial-out source stage that sits directly upstream of the 101 sequence detector.
- Accepts words over a valid/ready handshake and emits them one bit per clock on `x_out`; `x_out` drives the detector's `x` input.
- `x_valid` marks the clock cycles that carry payload, so downstream logic can gate or qualify detections.
- Supports back-to-back words with no bubble cycle, and a synchronous abort.

Parameters:
- WIDTH, 8, payload bits per word (legal range 2..32).
- MSB_FIRST, 1, 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first.
- IDLE_BIT, 0, level driven on `x_out` whenever `x_valid` = 0.
- CNT_W, 16, width of the `words_sent` counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset (0 = in reset).
- in_valid  input  1  upstream word available.
- in_data  input  WIDTH  word to serialize; sampled only on an accept edge.
- in_ready  output  1  block can accept a word this cycle.
- abort  input  1  synchronous; drop the word in flight.
- x_out  output  1  serial bit stream, feeds the detector's `x`.
- x_valid  output  1  `x_out` carries a payload bit this cycle.
- last_bit  output  1  `x_out` carries the final bit of the current word.
- busy  output  1  a word is being shifted (state SHIFT).
- words_sent  output  CNT_W  count of words fully emitted; wraps.

Behaviour:
- **Reset** (`rst`=0, asynchronous):
  - state = IDLE; shift register = 0; bit counter = 0.
  - `x_out` = IDLE_BIT; `x_valid` = 0; `last_bit` = 0; `busy` = 0; `words_sent` = 0.
  - `in_ready` is forced to 0 while `rst` = 0.
  - Reset mid-word discards the word; no partial count.
- **States:**
  - IDLE: nothing in flight; `in_ready` = 1.
  - SHIFT: a word is being emitted; `in_ready` = 1 only when bit counter = WIDTH-1 (last bit on the wire).
- `in_ready` is combinational from state, counter, `abort` and `rst` only. It never depends on `in_valid`.
- **Accept** = `in_valid` & `in_ready` & !`abort` at a rising edge. On an accept edge:
  - `x_out` <= first bit of `in_data`; remaining bits are loaded into the shift register.
  - counter <= 0; `x_valid` <= 1; state <= SHIFT.
  - Latency: first payload bit appears on `x_out` one cycle after the accept edge.
- **SHIFT, counter < WIDTH-1:** each edge shifts out the next bit (MSB_FIRST order) and increments the counter. `x_valid` stays 1.
- `last_bit` is registered, and is 1 exactly in the cycle where counter = WIDTH-1.
- **SHIFT, counter = WIDTH-1:**
  - `words_sent` increments (modulo 2^CNT_W) on this edge.
  - If accept on this edge: the new word's first bit follows immediately (no gap; `x_valid` stays 1).
  - Otherwise: state <= IDLE; `x_out` <= IDLE_BIT; `x_valid` <= 0.
- A word therefore occupies exactly WIDTH consecutive `x_valid` cycles. N back-to-back words give N·WIDTH contiguous valid cycles.
- **`abort` = 1 at an edge** (priority over accept and shift):
  - state <= IDLE; `x_out` <= IDLE_BIT; `x_valid` <= 0; `last_bit` <= 0; counter <= 0.
  - `words_sent` is unchanged, even if the aborted cycle was the last bit.
  - `in_ready` = 0 in any cycle where `abort` = 1.
- `abort` in IDLE has no effect other than holding `in_ready` low.
- `in_valid` without `in_ready`: no state change; upstream must hold the data stable until accepted.
- `busy` = (state == SHIFT), registered.
- No X propagation: `in_data` bits are never observed outside an accept edge.

Test Plan:
1. WIDTH=8, MSB_FIRST=1, accept 8'hA5 after reset release.
   - Expect `x_out` = 1,0,1,0,0,1,0,1 on cycles 1..8 after accept, `x_valid` = 1 for those 8 cycles.
   - `last_bit` = 1 only on cycle 8; `words_sent` = 1; then `x_out` = 0 and `x_valid` = 0.
   - Detector downstream pulses `z` for the first "101" (bits 0–2 of the stream).
2. MSB_FIRST=0, accept 8'h05.
   - Expect `x_out` = 1,0,1,0,0,0,0,0.
3. Back-to-back 8'hFF then 8'h00, with `in_valid` held high.
   - `in_ready` = 1 in IDLE and on cycle 8 of the first word.
   - 16 contiguous `x_valid` cycles: eight 1s then eight 0s.
   - `words_sent` = 2; no idle bubble between the words.
4. `abort` asserted during bit 4 of 8'hA5.
   - Next cycle `x_valid` = 0, `x_out` = IDLE_BIT, `busy` = 0, `words_sent` unchanged.
   - `in_ready` = 0 during the abort cycle and 1 the cycle after.
   - Also: abort coincident with `last_bit` and `in_valid` → no accept, count unchanged.
5. Async reset pulled low mid-word (bit 5).
   - All outputs at reset values immediately, without waiting for `clk`; `in_ready` = 0 while low.
   - After release, accept 8'h81 → `x_out` = 1,0,0,0,0,0,0,1; `words_sent` = 1.
6. CNT_W=4: send 17 words back-to-back.
   - `words_sent` wraps 15 → 0 and reads 1 at the end; `in_valid` stalls with `in_ready` low produce no output change.

Source files
------------

// File: rtl/seq_bit_serializer.sv
// Parallel-in, serial-out source for the 101 sequence detector: words arrive on a
// valid/ready handshake and leave one bit per clock on x_out, qualified by x_valid.
module seq_bit_serializer #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1,
    parameter bit IDLE_BIT  = 1'b0,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    input  logic             abort,
    output logic             x_out,
    output logic             x_valid,
    output logic             last_bit,
    output logic             busy,
    output logic [CNT_W-1:0] words_sent
);

    localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [BIT_W-1:0] LAST_IDX = BIT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [BIT_W-1:0] cnt_q, cnt_d;
    logic             x_out_q, x_out_d;
    logic             x_valid_q, x_valid_d;
    logic             last_bit_q, last_bit_d;
    logic [CNT_W-1:0] words_q, words_d;

    logic             accept;
    logic             first_bit;
    logic [WIDTH-1:0] load_sh;
    logic             next_bit;
    logic [WIDTH-1:0] shifted_sh;

    // Handshake: a word transfers on a rising edge where in_valid && in_ready.
    // in_ready depends only on state, bit counter, abort and rst, never on in_valid,
    // and rises on the last bit of a word so the next word follows with no gap.
    always_comb begin
        in_ready = 1'b0;
        if (rst && !abort) begin
            in_ready = (state_q == IDLE) || ((state_q == SHIFT) && (cnt_q == LAST_IDX));
        end
    end

    assign accept = in_valid && in_ready;

    always_comb begin
        if (MSB_FIRST != 0) begin
            first_bit  = in_data[WIDTH-1];
            load_sh    = in_data << 1;
            next_bit   = sh_q[WIDTH-1];
            shifted_sh = sh_q << 1;
        end else begin
            first_bit  = in_data[0];
            load_sh    = in_data >> 1;
            next_bit   = sh_q[0];
            shifted_sh = sh_q >> 1;
        end
    end

    always_comb begin
        state_d    = state_q;
        sh_d       = sh_q;
        cnt_d      = cnt_q;
        x_out_d    = x_out_q;
        x_valid_d  = x_valid_q;
        last_bit_d = last_bit_q;
        words_d    = words_q;

        if (abort) begin
            state_d    = IDLE;
            x_out_d    = IDLE_BIT;
            x_valid_d  = 1'b0;
            last_bit_d = 1'b0;
            cnt_d      = '0;
        end else if ((state_q == SHIFT) && (cnt_q != LAST_IDX)) begin
            x_out_d    = next_bit;
            sh_d       = shifted_sh;
            cnt_d      = cnt_q + BIT_W'(1);
            last_bit_d = (cnt_d == LAST_IDX);
        end else begin
            // Either idle, or the final bit of a word is on the wire this cycle.
            if (state_q == SHIFT) begin
                words_d = words_q + CNT_W'(1);
            end
            if (accept) begin
                state_d    = SHIFT;
                x_out_d    = first_bit;
                sh_d       = load_sh;
                cnt_d      = '0;
                x_valid_d  = 1'b1;
                last_bit_d = 1'b0;
            end else if (state_q == SHIFT) begin
                state_d    = IDLE;
                x_out_d    = IDLE_BIT;
                x_valid_d  = 1'b0;
                last_bit_d = 1'b0;
                cnt_d      = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            sh_q       <= '0;
            cnt_q      <= '0;
            x_out_q    <= IDLE_BIT;
            x_valid_q  <= 1'b0;
            last_bit_q <= 1'b0;
            words_q    <= '0;
        end else begin
            state_q    <= state_d;
            sh_q       <= sh_d;
            cnt_q      <= cnt_d;
            x_out_q    <= x_out_d;
            x_valid_q  <= x_valid_d;
            last_bit_q <= last_bit_d;
            words_q    <= words_d;
        end
    end

    assign x_out      = x_out_q;
    assign x_valid    = x_valid_q;
    assign last_bit   = last_bit_q;
    assign busy       = (state_q == SHIFT);
    assign words_sent = words_q;

endmodule

// File: tb/tb_seq_bit_serializer.sv
// Directed bench for seq_bit_serializer: three instances (MSB-first, LSB-first,
// 4-bit word counter) with bit-level scoreboards fed when words are accepted.
module tb_seq_bit_serializer;

    logic clk;
    logic rst;

    int checks = 0;
    int errors = 0;

    // ---------------- instance a: WIDTH=8, MSB_FIRST=1, CNT_W=16
    logic        a_in_valid, a_in_ready, a_abort, a_x_out, a_x_valid, a_last_bit, a_busy;
    logic [7:0]  a_in_data;
    logic [15:0] a_words;

    // ---------------- instance b: WIDTH=8, MSB_FIRST=0, CNT_W=16
    logic        b_in_valid, b_in_ready, b_abort, b_x_out, b_x_valid, b_last_bit, b_busy;
    logic [7:0]  b_in_data;
    logic [15:0] b_words;

    // ---------------- instance c: WIDTH=8, MSB_FIRST=1, CNT_W=4
    logic        c_in_valid, c_in_ready, c_abort, c_x_out, c_x_valid, c_last_bit, c_busy;
    logic [7:0]  c_in_data;
    logic [3:0]  c_words;

    logic [0:0] exp_a_q[$];
    logic [0:0] exp_b_q[$];
    logic [0:0] exp_c_q[$];
    int c_valid_cnt = 0;

    seq_bit_serializer #(.WIDTH(8), .MSB_FIRST(1), .IDLE_BIT(1'b0), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_data(a_in_data),
        .in_ready(a_in_ready), .abort(a_abort), .x_out(a_x_out), .x_valid(a_x_valid),
        .last_bit(a_last_bit), .busy(a_busy), .words_sent(a_words)
    );

    seq_bit_serializer #(.WIDTH(8), .MSB_FIRST(0), .IDLE_BIT(1'b0), .CNT_W(16)) dut_b (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_data(b_in_data),
        .in_ready(b_in_ready), .abort(b_abort), .x_out(b_x_out), .x_valid(b_x_valid),
        .last_bit(b_last_bit), .busy(b_busy), .words_sent(b_words)
    );

    seq_bit_serializer #(.WIDTH(8), .MSB_FIRST(1), .IDLE_BIT(1'b0), .CNT_W(4)) dut_c (
        .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_data(c_in_data),
        .in_ready(c_in_ready), .abort(c_abort), .x_out(c_x_out), .x_valid(c_x_valid),
        .last_bit(c_last_bit), .busy(c_busy), .words_sent(c_words)
    );

    // ---------------- clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Push the bits of d in wire order onto the scoreboard of instance which.
    task automatic push_word(input int which, input logic [7:0] d, input bit msb);
        logic [0:0] b;
        for (int i = 0; i < 8; i++) begin
            b = msb ? d[7-i] : d[i];
            case (which)
                0: exp_a_q.push_back(b);
                1: exp_b_q.push_back(b);
                default: exp_c_q.push_back(b);
            endcase
        end
    endtask

    // ---------------- scoreboard monitors
    always @(negedge clk) begin
        if (a_x_valid === 1'b1) begin
            checks++;
            assert (exp_a_q.size() > 0) else begin
                errors++;
                $error("FAIL a_sb_empty: observed x_valid=1 expected no payload");
            end
            if (exp_a_q.size() > 0) check("a_bit", a_x_out, exp_a_q.pop_front());
        end
    end

    always @(negedge clk) begin
        if (b_x_valid === 1'b1) begin
            checks++;
            assert (exp_b_q.size() > 0) else begin
                errors++;
                $error("FAIL b_sb_empty: observed x_valid=1 expected no payload");
            end
            if (exp_b_q.size() > 0) check("b_bit", b_x_out, exp_b_q.pop_front());
        end
    end

    always @(negedge clk) begin
        if (c_x_valid === 1'b1) begin
            c_valid_cnt++;
            checks++;
            assert (exp_c_q.size() > 0) else begin
                errors++;
                $error("FAIL c_sb_empty: observed x_valid=1 expected no payload");
            end
            if (exp_c_q.size() > 0) check("c_bit", c_x_out, exp_c_q.pop_front());
        end
    end

    // ---------------- watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed sequence
    initial begin
        logic [3:0] prev_c;
        bit         wrap_seen;
        int         remaining;
        int         guard;

        rst = 1'b0;
        a_in_valid = 0; a_in_data = '0; a_abort = 0;
        b_in_valid = 0; b_in_data = '0; b_abort = 0;
        c_in_valid = 0; c_in_data = '0; c_abort = 0;

        #2;
        check("rst_x_out", a_x_out, 0);
        check("rst_x_valid", a_x_valid, 0);
        check("rst_last_bit", a_last_bit, 0);
        check("rst_busy", a_busy, 0);
        check("rst_words", a_words, 0);
        check("rst_in_ready", a_in_ready, 0);

        tick(); tick();
        rst = 1'b1;
        #1;
        check("idle_in_ready", a_in_ready, 1);

        // Test 1: 8'hA5 MSB first
        a_in_valid = 1; a_in_data = 8'hA5;
        push_word(0, 8'hA5, 1);
        tick();
        a_in_valid = 0; a_in_data = 8'($urandom_range(0, 255));
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            check("t1_x_valid", a_x_valid, 1);
            check("t1_busy", a_busy, 1);
            check("t1_last_bit", a_last_bit, (k == 8) ? 1 : 0);
            check("t1_in_ready", a_in_ready, (k == 8) ? 1 : 0);
            tick();
        end
        @(negedge clk);
        check("t1_idle_valid", a_x_valid, 0);
        check("t1_idle_x_out", a_x_out, 0);
        check("t1_idle_busy", a_busy, 0);
        check("t1_words", a_words, 1);
        tick();

        // Test 2: 8'h05 LSB first
        b_in_valid = 1; b_in_data = 8'h05;
        push_word(1, 8'h05, 0);
        tick();
        b_in_valid = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            check("t2_x_valid", b_x_valid, 1);
            check("t2_last_bit", b_last_bit, (k == 8) ? 1 : 0);
            tick();
        end
        @(negedge clk);
        check("t2_idle_valid", b_x_valid, 0);
        check("t2_words", b_words, 1);
        tick();

        // Test 3: back-to-back FF then 00 with in_valid held high
        a_in_valid = 1; a_in_data = 8'hFF;
        check("t3_ready_idle", a_in_ready, 1);
        push_word(0, 8'hFF, 1);
        tick();
        a_in_data = 8'h00;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            check("t3_w0_valid", a_x_valid, 1);
            check("t3_w0_ready", a_in_ready, (k == 8) ? 1 : 0);
            if (k == 8) push_word(0, 8'h00, 1);
            tick();
        end
        a_in_valid = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            check("t3_w1_valid", a_x_valid, 1);
            check("t3_w1_last", a_last_bit, (k == 8) ? 1 : 0);
            tick();
        end
        @(negedge clk);
        check("t3_idle_valid", a_x_valid, 0);
        check("t3_words", a_words, 3);
        tick();

        // Test 4a: abort during bit 4
        a_in_valid = 1; a_in_data = 8'hA5;
        push_word(0, 8'hA5, 1);
        tick();
        a_in_valid = 0;
        repeat (3) tick();
        a_abort = 1;
        @(negedge clk);
        check("t4_ready_abort", a_in_ready, 0);
        tick();
        a_abort = 0;
        exp_a_q.delete();
        @(negedge clk);
        check("t4_valid", a_x_valid, 0);
        check("t4_x_out", a_x_out, 0);
        check("t4_busy", a_busy, 0);
        check("t4_last", a_last_bit, 0);
        check("t4_words", a_words, 3);
        check("t4_ready_after", a_in_ready, 1);
        tick();

        // Test 4b: abort coincident with last bit and in_valid
        a_in_valid = 1; a_in_data = 8'hA5;
        push_word(0, 8'hA5, 1);
        tick();
        a_in_valid = 0;
        repeat (7) tick();
        a_abort = 1; a_in_valid = 1; a_in_data = 8'h3C;
        @(negedge clk);
        check("t4b_last", a_last_bit, 1);
        check("t4b_ready", a_in_ready, 0);
        tick();
        a_abort = 0; a_in_valid = 0;
        @(negedge clk);
        check("t4b_valid", a_x_valid, 0);
        check("t4b_busy", a_busy, 0);
        check("t4b_words", a_words, 3);
        check("t4b_sb_drained", exp_a_q.size(), 0);
        tick();
        @(negedge clk);
        check("t4b_still_idle", a_x_valid, 0);
        tick();

        // Test 6: 17 back-to-back words on the 4-bit counter instance
        wrap_seen = 0;
        remaining = 17;
        guard = 0;
        c_in_valid = 1;
        c_in_data = 8'($urandom_range(0, 255));
        while (remaining > 0 && guard < 1000) begin
            prev_c = c_words;
            if (c_in_ready) begin
                push_word(2, c_in_data, 1);
                remaining--;
                tick();
                if (remaining > 0) c_in_data = 8'($urandom_range(0, 255));
                else c_in_valid = 0;
            end else begin
                tick();
            end
            if (prev_c == 4'd15 && c_words == 4'd0) wrap_seen = 1;
            guard++;
        end
        check("t6_accept_timeout", (guard < 1000) ? 1 : 0, 1);
        guard = 0;
        while (c_busy && guard < 100) begin
            prev_c = c_words;
            tick();
            if (prev_c == 4'd15 && c_words == 4'd0) wrap_seen = 1;
            guard++;
        end
        check("t6_drain_timeout", (guard < 100) ? 1 : 0, 1);
        check("t6_wrap_seen", wrap_seen, 1);
        check("t6_words", c_words, 1);
        check("t6_valid_cycles", c_valid_cnt, 136);
        check("t6_sb_drained", exp_c_q.size(), 0);

        // Test 5: async reset at bit 5, then 8'h81
        a_in_valid = 1; a_in_data = 8'hA5;
        push_word(0, 8'hA5, 1);
        tick();
        a_in_valid = 0;
        repeat (4) tick();
        #2;
        rst = 1'b0;
        #1;
        exp_a_q.delete();
        check("t5_x_out", a_x_out, 0);
        check("t5_x_valid", a_x_valid, 0);
        check("t5_last", a_last_bit, 0);
        check("t5_busy", a_busy, 0);
        check("t5_words", a_words, 0);
        check("t5_in_ready", a_in_ready, 0);
        check("t5_b_words", b_words, 0);
        a_in_valid = 1; a_in_data = 8'h81;
        tick();
        @(negedge clk);
        check("t5_ready_held", a_in_ready, 0);
        check("t5_no_accept", a_busy, 0);
        tick();
        rst = 1'b1;
        #1;
        check("t5_ready_release", a_in_ready, 1);
        push_word(0, 8'h81, 1);
        tick();
        a_in_valid = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            check("t5_valid", a_x_valid, 1);
            tick();
        end
        @(negedge clk);
        check("t5_idle_valid", a_x_valid, 0);
        check("t5_words_after", a_words, 1);
        check("t5_sb_drained", exp_a_q.size(), 0);
        check("t2_sb_drained", exp_b_q.size(), 0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
